// File: rtl/muldiv_seq_if.sv
// Bundle between the CPU control FSM, the multiply/divide sequencer and the shared adder.
interface muldiv_seq_if;
  logic        start;
  logic        op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_mode;
  logic [31:0] add_s;
  logic        add_cf;

  // Sequencer side
  modport slave (
    input  start, op, opa, opb, add_s, add_cf,
    output busy, done, hi, lo, div_zero, add_a, add_b, add_mode
  );

  // CPU / adder side
  modport master (
    output start, op, opa, opb, add_s, add_cf,
    input  busy, done, hi, lo, div_zero, add_a, add_b, add_mode
  );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MULU/DIVU sequencer. Borrows the shared 32-bit add/subtract unit:
// shift-add multiply and restoring divide, one iteration per cycle, 32 iterations.
module muldiv_seq (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        op_q;
  logic [31:0] m_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        div_zero_q;
  logic        busy_q;
  logic        done_q;

  logic        div_q_bit;
  logic [31:0] iter_hi;
  logic [31:0] iter_lo;

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = div_zero_q;

  // Adder operand steering; driven only while iterating, zero otherwise.
  always_comb begin
    bus.add_a    = '0;
    bus.add_b    = '0;
    bus.add_mode = 1'b0;
    if (state_q == StRun) begin
      if (!op_q) begin
        bus.add_a = hi_q;
        bus.add_b = lo_q[0] ? m_q : '0;
      end else begin
        bus.add_a    = {hi_q[30:0], lo_q[31]};
        bus.add_b    = m_q;
        bus.add_mode = 1'b1;
      end
    end
  end

  // Quotient bit: a set hi[31] means the shifted remainder is 33 bits wide and always >= m.
  assign div_q_bit = hi_q[31] | ~bus.add_cf;

  // One iteration's worth of hi/lo update for the current op.
  always_comb begin
    iter_hi = hi_q;
    iter_lo = lo_q;
    if (!op_q) begin
      iter_hi = {bus.add_cf, bus.add_s[31:1]};
      iter_lo = {bus.add_s[0], lo_q[31:1]};
    end else begin
      iter_hi = div_q_bit ? bus.add_s : {hi_q[30:0], lo_q[31]};
      iter_lo = {lo_q[30:0], div_q_bit};
    end
  end

  // Control FSM with registered busy/done and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= 1'b0;
      m_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q <= bus.op;
            if (bus.op && (bus.opb == '0)) begin
              // Divide by zero finishes immediately with all-ones quotient, dividend as remainder.
              lo_q       <= '1;
              hi_q       <= bus.opa;
              div_zero_q <= 1'b1;
              done_q     <= 1'b1;
              state_q    <= StDone;
            end else begin
              hi_q       <= '0;
              lo_q       <= bus.opa;
              m_q        <= bus.opb;
              cnt_q      <= '0;
              div_zero_q <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= StRun;
            end
          end
        end
        StRun: begin
          hi_q  <= iter_hi;
          lo_q  <= iter_lo;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq; models the shared combinational adder.
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared adder: add gives carry-out, subtract gives borrow (A < B).
  assign {bus.add_cf, bus.add_s} = bus.add_mode ? ({1'b0, bus.add_a} - {1'b0, bus.add_b})
                                                : ({1'b0, bus.add_a} + {1'b0, bus.add_b});

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Launch one op and wait for done. poke>0 pulses a stray start at that cycle of the wait.
  task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input int poke, output int lat, output logic mode_bad,
                       output logic busy_seen, output logic done_wide);
    lat       = 0;
    mode_bad  = 1'b0;
    busy_seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      bus.start = (i == poke);
      if (i == poke) begin
        bus.op  = ~op;
        bus.opb = '0;
      end
      if (bus.busy) begin
        busy_seen = 1'b1;
        if (bus.add_mode !== op) mode_bad = 1'b1;
      end
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    done_wide = bus.done;
  endtask

  vec_t vecs[10];
  int   lat;
  logic mode_bad, busy_seen, done_wide;
  int   extra_done;

  initial begin
    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[2] = '{1'b0, 32'd12345,     32'd0,         32'h0,         32'h0,         1'b0};
    vecs[3] = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'd1,         32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1,         1'b0};
    vecs[6] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         1'b0};
    vecs[7] = '{1'b1, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
    vecs[8] = '{1'b0, 32'd3,         32'd4,         32'd0,         32'd12,        1'b0};
    vecs[9] = '{1'b0, 32'd1000,      32'd1000,      32'd0,         32'd1000000,   1'b0};

    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.opa   = '0;
    bus.opb   = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'b0, bus.busy}, 32'd0);
    check("reset done", {31'b0, bus.done}, 32'd0);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    check("reset div_zero", {31'b0, bus.div_zero}, 32'd0);
    check("reset add_a", bus.add_a, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      do_op(vecs[k].op, vecs[k].a, vecs[k].b, 0, lat, mode_bad, busy_seen, done_wide);
      check($sformatf("v%0d hi", k), bus.hi, vecs[k].hi);
      check($sformatf("v%0d lo", k), bus.lo, vecs[k].lo);
      check($sformatf("v%0d div_zero", k), {31'b0, bus.div_zero}, {31'b0, vecs[k].dz});
      check($sformatf("v%0d latency", k), lat, vecs[k].dz ? 32'd1 : 32'd33);
      check($sformatf("v%0d busy seen", k), {31'b0, busy_seen}, {31'b0, ~vecs[k].dz});
      check($sformatf("v%0d add_mode", k), {31'b0, mode_bad}, 32'd0);
      check($sformatf("v%0d done width", k), {31'b0, done_wide}, 32'd0);
    end

    // Stray start mid-multiply (a DIVU by zero) must be ignored.
    do_op(1'b0, 32'h0001_0000, 32'h0001_0000, 5, lat, mode_bad, busy_seen, done_wide);
    check("ignored start hi", bus.hi, 32'd1);
    check("ignored start lo", bus.lo, 32'd0);
    check("ignored start div_zero", {31'b0, bus.div_zero}, 32'd0);
    check("ignored start latency", lat, 32'd33);

    // Reset mid-run aborts without a done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.opa   = 32'hFFFF_FFFF;
    bus.opb   = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre-abort busy", {31'b0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort busy", {31'b0, bus.busy}, 32'd0);
    check("abort done", {31'b0, bus.done}, 32'd0);
    check("abort hi", bus.hi, 32'd0);
    check("abort lo", bus.lo, 32'd0);
    check("abort add_a", bus.add_a, 32'd0);
    check("abort add_b", bus.add_b, 32'd0);
    check("abort add_mode", {31'b0, bus.add_mode}, 32'd0);
    extra_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    check("abort no done", extra_done, 32'd0);

    do_op(1'b1, 32'd100, 32'd7, 0, lat, mode_bad, busy_seen, done_wide);
    check("post-abort quotient", bus.lo, 32'd14);
    check("post-abort remainder", bus.hi, 32'd2);
    check("post-abort latency", lat, 32'd33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
